// File: rtl/simple_ext_module_pkg.sv
`default_nettype none
// ============================================================================
// Module      : simple_ext_module_pkg
// Description : Shared defaults and saturating-increment helper
// Revision    : 1.0
// ============================================================================
package simple_ext_module_pkg;

   localparam int unsigned c_DEFAULT_WIDTH     = 16;
   localparam int unsigned c_DEFAULT_CNT_WIDTH = 16;

   // Operates on 32-bit containers; callers cast to and from their own width.
   function automatic logic [31:0] sat_inc(input logic [31:0] value,
                                           input logic [31:0] max_value);
      sat_inc = (value >= max_value) ? max_value : value + 32'd1;
   endfunction

endpackage
`default_nettype wire

// File: rtl/simple_ext_module.sv
`default_nettype none
// ============================================================================
// Module      : simple_ext_module
// Description : Zero-latency pass-through with registered shadow and change count
// Revision    : 1.0
// ============================================================================
module simple_ext_module
   import simple_ext_module_pkg::*;
#(
   parameter int unsigned WIDTH     = c_DEFAULT_WIDTH,
   parameter int unsigned CNT_WIDTH = c_DEFAULT_CNT_WIDTH
) (
   input  logic                 clock,
   input  logic                 reset,
   input  logic [WIDTH-1:0]     foo,
   output logic [WIDTH-1:0]     bar,
   output logic [WIDTH-1:0]     bar_q,
   output logic                 sampled,
   output logic                 foo_changed,
   output logic [CNT_WIDTH-1:0] change_count
);

   localparam logic [CNT_WIDTH-1:0] c_CNT_MAX = '1;

   logic [WIDTH-1:0]     r_bar_q;
   logic                 r_sampled;
   logic [CNT_WIDTH-1:0] r_count;
   logic                 w_foo_changed;
   logic [31:0]          w_count_inc;

   assign bar = foo;

   assign w_foo_changed = r_sampled & (foo != r_bar_q);
   assign w_count_inc   = sat_inc(32'(r_count), 32'(c_CNT_MAX));

   // Reset has priority over a simultaneous change, so the counter clears.
   always_ff @(posedge clock) begin
      if (!reset) begin
         r_bar_q   <= '0;
         r_sampled <= 1'b0;
         r_count   <= '0;
      end else begin
         r_bar_q   <= foo;
         r_sampled <= 1'b1;
         if (w_foo_changed) begin
            r_count <= CNT_WIDTH'(w_count_inc);
         end
      end
   end

   assign bar_q        = r_bar_q;
   assign sampled      = r_sampled;
   assign foo_changed  = w_foo_changed;
   assign change_count = r_count;

endmodule
`default_nettype wire

// File: tb/tb_simple_ext_module.sv
`default_nettype none
// ============================================================================
// Module      : tb_simple_ext_module
// Description : Self-checking bench for simple_ext_module (default and 4-bit counter)
// Revision    : 1.0
// ============================================================================
module tb_simple_ext_module;

   logic        clock;
   logic        reset;
   logic [15:0] foo;

   logic [15:0] bar,   bar_s;
   logic [15:0] bar_q, bar_q_s;
   logic        sampled, sampled_s;
   logic        foo_changed, foo_changed_s;
   logic [15:0] change_count;
   logic [3:0]  change_count_s;

   int n_tests = 0;
   int n_fail  = 0;

   // Reference state
   bit          m_known   = 0;
   logic [15:0] m_bar_q;
   bit          m_sampled;
   int          m_cnt16;
   int          m_cnt4;

   simple_ext_module dut (
      .clock        (clock),
      .reset        (reset),
      .foo          (foo),
      .bar          (bar),
      .bar_q        (bar_q),
      .sampled      (sampled),
      .foo_changed  (foo_changed),
      .change_count (change_count)
   );

   simple_ext_module #(.WIDTH(16), .CNT_WIDTH(4)) dut_s (
      .clock        (clock),
      .reset        (reset),
      .foo          (foo),
      .bar          (bar_s),
      .bar_q        (bar_q_s),
      .sampled      (sampled_s),
      .foo_changed  (foo_changed_s),
      .change_count (change_count_s)
   );

   initial clock = 1'b0;
   always #5 clock = ~clock;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_tests++;
      if (obs !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, obs, exp, $time);
      end
   endtask

   // Apply inputs, check outputs mid-cycle, then advance the model at the edge.
   task automatic step(input logic rst_n, input logic [15:0] f);
      bit exp_chg;
      reset = rst_n;
      foo   = f;
      @(negedge clock);
      check("bar", 32'(bar), 32'(f));
      check("bar_s", 32'(bar_s), 32'(f));
      if (m_known) begin
         exp_chg = m_sampled && (f != m_bar_q);
         check("bar_q", 32'(bar_q), 32'(m_bar_q));
         check("sampled", 32'(sampled), 32'(m_sampled));
         check("foo_changed", 32'(foo_changed), 32'(exp_chg));
         check("change_count", 32'(change_count), 32'(m_cnt16));
         check("bar_q_s", 32'(bar_q_s), 32'(m_bar_q));
         check("foo_changed_s", 32'(foo_changed_s), 32'(exp_chg));
         check("change_count_s", 32'(change_count_s), 32'(m_cnt4));
      end
      @(posedge clock);
      if (!rst_n) begin
         m_known   = 1;
         m_bar_q   = 16'h0;
         m_sampled = 0;
         m_cnt16   = 0;
         m_cnt4    = 0;
      end else if (m_known) begin
         if (m_sampled && (f != m_bar_q)) begin
            m_cnt16 = (m_cnt16 + 1 > 65535) ? 65535 : m_cnt16 + 1;
            m_cnt4  = (m_cnt4 + 1 > 15) ? 15 : m_cnt4 + 1;
         end
         m_bar_q   = f;
         m_sampled = 1;
      end
      #1;
   endtask

   initial begin
      logic [15:0] f;
      reset = 1'b0;
      foo   = 16'h04D2;

      // Constant input through reset and beyond
      step(1'b0, 16'h04D2);
      step(1'b0, 16'h04D2);
      for (int i = 0; i < 6; i++) step(1'b1, 16'h04D2);
      check("const_cnt", 32'(change_count), 32'd0);
      check("const_bar_q", 32'(bar_q), 32'h04D2);

      // Short sequence with two changes
      step(1'b0, 16'h0001);
      step(1'b1, 16'h0001);
      step(1'b1, 16'h0002);
      step(1'b1, 16'h0002);
      step(1'b1, 16'h0003);
      step(1'b1, 16'h0003);
      check("seq_cnt", 32'(change_count), 32'd2);

      // Input moves while held in reset
      for (int i = 0; i < 5; i++) step(1'b0, 16'($urandom));
      check("rst_hold_cnt", 32'(change_count), 32'd0);

      // Count to 5, then reset during toggling
      f = 16'h00FF;
      step(1'b1, f);
      for (int i = 0; i < 5; i++) begin
         f = ~f;
         step(1'b1, f);
      end
      step(1'b1, f);
      check("five_cnt", 32'(change_count), 32'd5);
      f = ~f;
      step(1'b0, f);
      f = ~f;
      step(1'b1, f);
      check("post_rst_cnt", 32'(change_count), 32'd0);

      // Toggle past saturation of the 4-bit counter
      for (int i = 0; i < 24; i++) begin
         f = ~f;
         step(1'b1, f);
      end
      step(1'b1, f);
      check("sat4", 32'(change_count_s), 32'd15);
      check("cnt16_past_15", 32'(change_count), 32'd24);

      // Random traffic with occasional reset
      for (int i = 0; i < 1000; i++) begin
         f = ($urandom_range(0, 3) == 0) ? f : 16'($urandom);
         step(($urandom_range(0, 49) == 0) ? 1'b0 : 1'b1, f);
      end

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
`default_nettype wire
